// File: rtl/depth_frame_store_pkg.sv
// Shared constants for the depth frame store: header bytes, FSM state codes, default thresholds.
package depth_frame_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned STATE_W = 3;

  localparam logic [7:0] HDR0 = 8'hDD;
  localparam logic [7:0] HDR1 = 8'hCC;
  localparam logic [7:0] HDR2 = 8'hBB;
  localparam logic [7:0] HDR3 = 8'hAA;

  localparam logic [STATE_W-1:0] ST_H0    = 3'd0;
  localparam logic [STATE_W-1:0] ST_H1    = 3'd1;
  localparam logic [STATE_W-1:0] ST_H2    = 3'd2;
  localparam logic [STATE_W-1:0] ST_H3    = 3'd3;
  localparam logic [STATE_W-1:0] ST_RX_HI = 3'd4;
  localparam logic [STATE_W-1:0] ST_RX_LO = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

  localparam int unsigned DEF_THRESH    = 30;
  localparam int unsigned DEF_MAX_DEPTH = 4095;

  // A header mismatch restarts the hunt, keeping a DD that may begin a new header.
  function automatic logic [STATE_W-1:0] hunt_restart(input logic [7:0] b);
    return (b == HDR0) ? ST_H1 : ST_H0;
  endfunction

endpackage

// File: rtl/depth_frame_store_if.sv
// FIFO byte stream, mode select and foreground-map readout bundle.
// FRAME_COUNT_EN adds frame_count and ref_valid.
interface depth_frame_store_if #(
  parameter int unsigned LOGSIZE = 19
) ();
  logic               write_btn;
  logic               oe;
  logic               rd;
  logic [7:0]         data;
  logic [LOGSIZE-1:0] read_index;
  logic               ready;
  logic               bin_out;
`ifdef FRAME_COUNT_EN
  logic [7:0]         frame_count;
  logic               ref_valid;

  modport master (output write_btn, oe, rd, data, read_index,
                  input  ready, bin_out, frame_count, ref_valid);
  modport slave  (input  write_btn, oe, rd, data, read_index,
                  output ready, bin_out, frame_count, ref_valid);
`else
  modport master (output write_btn, oe, rd, data, read_index,
                  input  ready, bin_out);
  modport slave  (input  write_btn, oe, rd, data, read_index,
                  output ready, bin_out);
`endif
endinterface

// File: rtl/depth_frame_store_compare.sv
// Combinational foreground decision for one depth word against its reference.
module depth_compare
  import depth_frame_pkg::*;
#(
  parameter int unsigned THRESH    = DEF_THRESH,
  parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] ref_word_i,
  output logic              fg_c
);
  logic              closer_c;
  logic [WORD_W-1:0] diff_c;

  always_comb begin
    closer_c = (ref_word_i >= word_i);
    diff_c   = closer_c ? (ref_word_i - word_i) : WORD_W'(0);
    fg_c     = (word_i != WORD_W'(0)) &&
               (word_i <= WORD_W'(MAX_DEPTH)) &&
               closer_c &&
               (diff_c <= WORD_W'(THRESH));
  end
endmodule

// File: rtl/depth_frame_store.sv
// Header-locked depth frame capture/compare with a 1-bit foreground map readout.
// Optional FRAME_COUNT_EN: frame counter and reference-valid tracking.
module depth_frame_store
  import depth_frame_pkg::*;
#(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned LOGSIZE   = 19,
  parameter int unsigned THRESH    = DEF_THRESH,
  parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
) (
  input logic              clk,
  input logic              reset,
  depth_frame_store_if.slave bus
);
  localparam int unsigned NPIX = WIDTH * HEIGHT;

  logic [STATE_W-1:0] state_q, state_d;
  logic [LOGSIZE-1:0] cnt_q, cnt_d;
  logic [7:0]         hi_q, hi_d;
  logic               ready_q, ready_d;
  logic               bin_out_q, bin_out_d;

  logic [WORD_W-1:0]  ref_mem [NPIX];
  logic               bin_mem [NPIX];

  logic               accept_c;
  logic [WORD_W-1:0]  word_c;
  logic [WORD_W-1:0]  ref_rd_c;
  logic               fg_c;
  logic               fg_wr_c;
  logic               ref_we_c;
  logic               bin_we_c;

`ifdef FRAME_COUNT_EN
  logic [7:0]         frame_count_q, frame_count_d;
  logic               ref_valid_q, ref_valid_d;
`endif

  assign accept_c = bus.oe & bus.rd;
  assign word_c   = {hi_q, bus.data};
  assign ref_rd_c = ref_mem[cnt_q];

  depth_compare #(
    .THRESH    (THRESH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_compare (
    .word_i     (word_c),
    .ref_word_i (ref_rd_c),
    .fg_c       (fg_c)
  );

  // Until a reference exists, compare frames produce an empty map.
`ifdef FRAME_COUNT_EN
  assign fg_wr_c = fg_c & ref_valid_q;
`else
  assign fg_wr_c = fg_c;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    ready_d  = ready_q;
    ref_we_c = 1'b0;
    bin_we_c = 1'b0;
`ifdef FRAME_COUNT_EN
    frame_count_d = frame_count_q;
    ref_valid_d   = ref_valid_q;
`endif
    case (state_q)
      ST_H0: if (accept_c) state_d = hunt_restart(bus.data);
      ST_H1: if (accept_c) state_d = (bus.data == HDR1) ? ST_H2 : hunt_restart(bus.data);
      ST_H2: if (accept_c) state_d = (bus.data == HDR2) ? ST_H3 : hunt_restart(bus.data);
      ST_H3: begin
        if (accept_c) begin
          if (bus.data == HDR3) begin
            state_d = ST_RX_HI;
            cnt_d   = LOGSIZE'(0);
            ready_d = 1'b0;
          end else begin
            state_d = hunt_restart(bus.data);
          end
        end
      end
      ST_RX_HI: begin
        if (accept_c) begin
          hi_d    = bus.data;
          state_d = ST_RX_LO;
        end
      end
      ST_RX_LO: begin
        if (accept_c) begin
          ref_we_c = bus.write_btn;
          bin_we_c = ~bus.write_btn;
          if (32'(cnt_q) == NPIX - 1) begin
            state_d = ST_DONE;
`ifdef FRAME_COUNT_EN
            if (bus.write_btn) ref_valid_d = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + LOGSIZE'(1);
            state_d = ST_RX_HI;
          end
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_H0;
`ifdef FRAME_COUNT_EN
        frame_count_d = frame_count_q + 8'(1);
`endif
      end
      default: state_d = ST_H0;
    endcase
  end

  // Registered readout; a same-cycle write is not visible until the next read.
  always_comb begin
    bin_out_d = 1'b0;
    if (32'(bus.read_index) < NPIX) bin_out_d = bin_mem[bus.read_index];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_H0;
      cnt_q     <= '0;
      hi_q      <= '0;
      ready_q   <= 1'b0;
      bin_out_q <= 1'b0;
`ifdef FRAME_COUNT_EN
      frame_count_q <= '0;
      ref_valid_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      ready_q   <= ready_d;
      bin_out_q <= bin_out_d;
`ifdef FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
      ref_valid_q   <= ref_valid_d;
`endif
    end
  end

  // Frame memories are plain RAM: no reset, contents survive an aborted frame.
  always_ff @(posedge clk) begin
    if (ref_we_c) ref_mem[cnt_q] <= word_c;
    if (bin_we_c) bin_mem[cnt_q] <= fg_wr_c;
  end

  assign bus.ready   = ready_q;
  assign bus.bin_out = bin_out_q;
`ifdef FRAME_COUNT_EN
  assign bus.frame_count = frame_count_q;
  assign bus.ref_valid   = ref_valid_q;
`endif

endmodule

// File: tb/tb_depth_frame_store.sv
// Self-checking bench for depth_frame_store on a 4x4 frame.
module tb_depth_frame_store;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned LS = 4;
  localparam int unsigned N  = W * H;

  typedef logic [15:0] frame_t [N];
  typedef bit map_t [N];
  typedef struct {
    logic [15:0] cap_w;
    logic [15:0] cmp_w;
    bit          exp_fg;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  depth_frame_store_if #(.LOGSIZE(LS)) bus ();

  depth_frame_store #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .LOGSIZE (LS)
  ) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_m [N];
  map_t        bin_m;
  bit          ref_valid_m;
  int          frames_m;
  vec_t        vt [N];

  function automatic bit fg_rule(input int r, input int w);
    return (w != 0) && (w <= 4095) && (r >= w) && (r - w <= 30);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Idle cycles: oe and rd never both high, so nothing is accepted.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.oe   = 1'($urandom_range(0, 1));
      bus.rd   = ~bus.oe;
      bus.data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.oe = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.data = b;
    bus.oe   = 1'b1;
    bus.rd   = 1'b1;
    @(posedge clk);
    #1;
    bus.oe   = 1'b0;
    bus.rd   = 1'b0;
  endtask

  task automatic send_header();
    send_byte(8'hDD);
    send_byte(8'hCC);
    send_byte(8'hBB);
    send_byte(8'hAA);
    check("ready low after AA", 32'(bus.ready), 32'd0);
  endtask

  task automatic send_words(input frame_t f, input bit wb, input int nw,
                            input int stall_at, input int stall_len);
    logic [15:0] w;
    bus.write_btn = wb;
    for (int i = 0; i < nw; i++) begin
      w = f[i];
      send_byte(w[15:8]);
      if (i == stall_at) idle(stall_len);
      send_byte(w[7:0]);
      if (wb) ref_m[i] = w;
      else    bin_m[i] = fg_rule(int'(ref_m[i]), int'(w))
`ifdef FRAME_COUNT_EN
                         && ref_valid_m
`endif
                         ;
    end
  endtask

  task automatic finish_frame(input bit wb);
    int k = 0;
    while (bus.ready !== 1'b1 && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ready after frame", 32'(bus.ready), 32'd1);
    frames_m++;
    if (wb) ref_valid_m = 1'b1;
`ifdef FRAME_COUNT_EN
    check("frame_count", 32'(bus.frame_count), 32'(frames_m % 256));
    check("ref_valid", 32'(bus.ref_valid), 32'(ref_valid_m));
`endif
    idle(2);
  endtask

  // Continuous readout sweep: one new index per cycle, result one cycle later.
  task automatic sweep(input string tag, input map_t exp);
    for (int i = 0; i < int'(N); i++) begin
      bus.read_index = LS'(i);
      if (i > 0) check($sformatf("%s hold[%0d]", tag, i), 32'(bus.bin_out), 32'(exp[i-1]));
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(bus.bin_out), 32'(exp[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t cap, cmp, f;
    map_t   tmap;
    bit     wb;
    int     r, d, nwords, stall;

    vt[0]  = '{16'd1000, 16'd995,  1'b1};
    vt[1]  = '{16'd2000, 16'd1997, 1'b1};
    vt[2]  = '{16'd3000, 16'd2985, 1'b1};
    vt[3]  = '{16'd4000, 16'd4000, 1'b1};
    vt[4]  = '{16'd4444, 16'd4443, 1'b0};
    vt[5]  = '{16'd3333, 16'd3334, 1'b0};
    vt[6]  = '{16'd2222, 16'd3000, 1'b0};
    vt[7]  = '{16'd1111, 16'd1010, 1'b0};
    vt[8]  = '{16'd849,  16'd820,  1'b1};
    vt[9]  = '{16'd850,  16'd820,  1'b1};
    vt[10] = '{16'd851,  16'd820,  1'b0};
    vt[11] = '{16'd852,  16'd820,  1'b0};
    vt[12] = '{16'd1,    16'd0,    1'b0};
    vt[13] = '{16'd2,    16'd0,    1'b0};
    vt[14] = '{16'd3,    16'd0,    1'b0};
    vt[15] = '{16'd0,    16'd0,    1'b0};
    for (int i = 0; i < int'(N); i++) begin
      cap[i]  = vt[i].cap_w;
      cmp[i]  = vt[i].cmp_w;
      tmap[i] = vt[i].exp_fg;
      bin_m[i] = 1'b0;
      ref_m[i] = '0;
    end
    ref_valid_m = 1'b0;
    frames_m    = 0;

    reset_n        = 1'b0;
    bus.write_btn  = 1'b0;
    bus.oe         = 1'b0;
    bus.rd         = 1'b0;
    bus.data       = 8'h00;
    bus.read_index = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'd0);
    check("reset bin_out", 32'(bus.bin_out), 32'd0);
    #3;
    reset_n = 1'b1;
    idle(2);
    check("ready idle", 32'(bus.ready), 32'd0);

    // Capture frame with leading zero bytes.
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    send_header();
    send_words(cap, 1'b1, N, -1, 0);
    finish_frame(1'b1);

    // Compare frame against table.
    send_header();
    send_words(cmp, 1'b0, N, -1, 0);
    finish_frame(1'b0);
    sweep("t2 map", tmap);

    // Resync on a broken header; pixel 0 is the first word after AA.
    send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
    check("resync ready low", 32'(bus.ready), 32'd0);
    f = cmp;
    f[0] = 16'd0;
    send_words(f, 1'b0, N, -1, 0);
    finish_frame(1'b0);
    sweep("t3 map", bin_m);
    check("t3 pixel0", 32'(bin_m[0]), 32'd0);

    // Stall between high and low byte of word 5.
    send_header();
    send_words(cmp, 1'b0, N, 5, 20);
    finish_frame(1'b0);
    sweep("t4 map", tmap);

    // Reset after six zero words; those writes persist.
    for (int i = 0; i < int'(N); i++) f[i] = 16'd0;
    send_header();
    send_words(f, 1'b0, 6, -1, 0);
    idle(1);
    reset_n = 1'b0;
    #2;
    check("midreset ready", 32'(bus.ready), 32'd0);
    check("midreset bin_out", 32'(bus.bin_out), 32'd0);
    idle(2);
    #3;
    reset_n = 1'b1;
    ref_valid_m = 1'b0;
    frames_m    = 0;
    idle(3);
    check("post-reset ready", 32'(bus.ready), 32'd0);
    sweep("t5 partial", bin_m);
    send_header();
    send_words(cmp, 1'b0, N, -1, 0);
    finish_frame(1'b0);
`ifdef FRAME_COUNT_EN
    sweep("t5 map", bin_m);
`else
    sweep("t5 map", tmap);
`endif

    // Randomized frames against the reference model.
    for (int fr = 0; fr < 8; fr++) begin
      wb = (fr == 0) || ($urandom_range(0, 3) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if (wb) begin
          f[i] = 16'($urandom_range(0, 4200));
        end else if ($urandom_range(0, 3) == 0) begin
          f[i] = 16'($urandom_range(0, 5000));
        end else begin
          r = int'(ref_m[i]);
          d = int'($urandom_range(0, 40)) - 4;
          f[i] = (r > d) ? 16'(r - d) : 16'd0;
        end
      end
      nwords = int'($urandom_range(0, 3));
      for (int k = 0; k < nwords; k++) send_byte(8'($urandom_range(0, 127)));
      send_header();
      stall = int'($urandom_range(0, N - 1));
      send_words(f, wb, N, stall, int'($urandom_range(0, 5)));
      finish_frame(wb);
      sweep($sformatf("rand%0d map", fr), bin_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/depth_frame_store.md
Name: depth_frame_store

Overview:
- Receives a byte stream from the FT2232 FIFO reader.
- Locks onto the 4-byte frame header DD CC BB AA, then assembles WIDTH*HEIGHT 16-bit big-endian depth words.
- With write_btn high, the frame is stored as the reference frame. With write_btn low, each word is compared against the reference and a 1-bit foreground map is written.
- The map is read back by the VGA side through read_index/bin_out.

Parameters:
- WIDTH, 640, frame width in pixels.
- HEIGHT, 480, frame height in pixels.
- LOGSIZE, 19, address width; 2^LOGSIZE >= WIDTH*HEIGHT.
- THRESH, 30, maximum ref-minus-new difference that still marks a pixel as foreground.
- MAX_DEPTH, 4095, largest valid depth word.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- write_btn  input  1  1 = capture reference frame; 0 = compare frame
- oe  input  1  FIFO output enable, active-high
- rd  input  1  FIFO read strobe, active-high
- data  input  8  FIFO byte
- read_index  input  LOGSIZE  pixel address for readout
- ready  output  1  at least one frame fully processed; not currently receiving
- bin_out  output  1  foreground bit at read_index

Behaviour:
- One clock, clk. reset is asynchronous and active-low. All state and outputs are cleared during reset: FSM=HUNT, counters=0, ready=0, bin_out=0.
- Byte accepted on a rising clk edge when oe && rd. No other cycle advances the FSM.
- HUNT FSM sub-states H0..H3 expect DD, CC, BB, AA in order.
  - On a mismatch: return to H0, or to H1 if the byte is DD.
  - Leading 00 bytes are ignored.
  - AA in H3 enters RX_HI with pixel counter=0.
- RX_HI: the byte is latched as the high byte, then go to RX_LO.
- RX_LO: word = {hi, byte}.
  - write_btn sampled in this cycle selects the mode.
  - Capture mode: ref_mem[cnt] <= word.
  - Compare mode: bin_mem[cnt] <= fg.
  - cnt increments. When cnt reaches WIDTH*HEIGHT-1, go to DONE; otherwise go to RX_HI.
- DONE: ready <= 1; return to HUNT next cycle.
- ready deasserts when the header AA byte is accepted. It reasserts in DONE.
- Foreground rule: fg = (word != 0) && (word <= MAX_DEPTH) && (ref >= word) && (ref - word <= THRESH). The subtraction is 16-bit unsigned, performed only when ref >= word.
- Capture mode leaves bin_mem untouched. Compare mode leaves ref_mem untouched.
- Memories:
  - ref_mem: WIDTH*HEIGHT x 16.
  - bin_mem: WIDTH*HEIGHT x 1.
  - Both are inferred RAM and are not cleared by reset. Contents read before the first write are don't-care.
- Readout: bin_out <= bin_mem[read_index] registered, one clk latency. Read and write to the same address in the same cycle return the old bit.
- read_index >= WIDTH*HEIGHT: bin_out=0.
- If the stream stalls mid-frame (oe/rd low), the FSM holds indefinitely.
- If reset is asserted mid-frame, the partial frame is discarded and memories keep any words already written.

Optional Feature:
- FRAME_COUNT_EN defined:
  - Adds output frame_count[7:0], reset to 0.
  - Increments in DONE and wraps 255->0.
  - Also adds output ref_valid: set by the first completed capture frame, cleared only by reset. While ref_valid=0, compare frames write all 0.
- Not defined: no extra ports. Compare mode uses ref_mem contents as-is.

Decomposition:
- Package depth_frame_pkg:
  - Header byte constants HDR0..HDR3 = DD, CC, BB, AA.
  - FSM state enum: H0, H1, H2, H3, RX_HI, RX_LO, DONE.
  - Default THRESH and MAX_DEPTH.
- One sub-module depth_compare: combinational fg from (word, ref), parameterized by THRESH and MAX_DEPTH.

Test Plan (WIDTH=4, HEIGHT=4, LOGSIZE=4):
1. Capture frame:
   - Stimulus: bytes 00 00 00 00 DD CC BB AA, then words 1000, 2000, 3000, 4000, 4444, 3333, 2222, 1111, 849, 850, 851, 852, 1, 2, 3, 0, with write_btn=1.
   - Response: ready=1 after DONE; ref_mem holds those words.
2. Compare frame:
   - Stimulus: header, then words 995, 1997, 2985, 4000, 4443, 3334, 3000, 1010, 820, 820, 820, 820, 0, 0, 0, 0, with write_btn=0.
   - Response: bin_out for indices 0..15 = 1111 0000 1100 0000. Index 4 is 0 because 4443 > MAX_DEPTH.
3. Header resync:
   - Stimulus: bytes DD CC DD CC BB AA, then a frame.
   - Response: frame is accepted; pixel 0 = the first word after AA.
4. Stall:
   - Stimulus: deassert rd for 20 cycles between the high and low byte of word 5.
   - Response: word assembled correctly; result identical to test 2.
5. Reset mid-frame:
   - Stimulus: assert reset after 6 words.
   - Response: ready=0, FSM in H0; the next full frame behaves normally.
6. Readout:
   - Stimulus: sweep read_index 0..15 continuously.
   - Response: bin_out matches the test 2 map with one-cycle latency.
